// File: rtl/cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_adaptor
//
// Bridges the cache's single-line physical-memory port to a burst memory that
// moves BURST_W bits per handshake. A line read collects BEATS beats into
// line_o; a line write latches line_i and plays it out beat by beat, lowest
// beat first. A one-cycle resp_o tells the cache the line transfer is done.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   synchronous active-low reset
//   line_i     in   LINE_W   write line from the cache datapath
//   line_o     out  LINE_W   assembled read line to the cache datapath
//   address_i  in   ADDR_W   line address from the cache
//   read_i     in   line read request
//   write_i    in   line write request
//   resp_o     out  line transfer complete (one-cycle pulse)
//   burst_i    in   BURST_W  read beat from memory
//   burst_o    out  BURST_W  write beat to memory
//   address_o  out  ADDR_W   line-aligned address to memory
//   read_o     out  burst read request
//   write_o    out  burst write request
//   resp_i     in   beat handshake, one beat per cycle it is high
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a line request; memory handshake ignored
// READ   | read_o high, collecting beats into line_o
// WRITE  | write_o high, presenting buffered beats on burst_o
// DONE   | resp_o pulse to the cache, back to IDLE next cycle
// -----------------------------------------------------------------------------
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Byte-offset bits of a line; these are forced to zero on the memory side.
  localparam int OFS_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if ((LINE_W % BURST_W) != 0) begin : g_bad_widths
    $error("cacheline_adaptor: LINE_W must be a multiple of BURST_W");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [LINE_W-1:0]   r_buf;
  logic                w_beat;
  logic                w_last;
  logic                w_unused;

  // Only READ and WRITE consume the memory handshake.
  assign w_beat = resp_i && ((r_state == READ) || (r_state == WRITE));
  assign w_last = w_beat && (r_cnt == LAST_BEAT);

  // The byte offset of the incoming address never reaches memory.
  assign w_unused = ^address_i[OFS_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_next  = r_state;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    burst_o = '0;
    case (r_state)
      IDLE: begin
        // Read has priority when both requests arrive together.
        if (read_i) begin
          w_next = READ;
        end else if (write_i) begin
          w_next = WRITE;
        end
      end
      READ: begin
        read_o = 1'b1;
        if (w_last) begin
          w_next = DONE;
        end
      end
      WRITE: begin
        write_o = 1'b1;
        // The buffer shifts down one beat per handshake, so the current
        // beat always sits in the low slice.
        burst_o = r_buf[BURST_W-1:0];
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        resp_o = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Datapath: address latch, beat counter, write buffer, read line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_buf     <= '0;
      line_o    <= '0;
      address_o <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (read_i || write_i) begin
            address_o <= {address_i[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
            r_cnt     <= '0;
          end
          // Only a pure write loads the buffer; a concurrent read wins.
          if (!read_i && write_i) begin
            r_buf <= line_i;
          end
        end
        READ: begin
          if (resp_i) begin
            for (int b = 0; b < BEATS; b++) begin
              if (r_cnt == CNT_W'(b)) begin
                line_o[b*BURST_W +: BURST_W] <= burst_i;
              end
            end
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          if (resp_i) begin
            r_buf <= r_buf >> BURST_W;
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// tb_cacheline_adaptor
//
// Self-checking bench for cacheline_adaptor. Expected addresses, read lines
// and write beats are queued when a request is issued and popped when the
// DUT presents the matching output.
// -----------------------------------------------------------------------------
module tb_cacheline_adaptor;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int ADDR_W  = 32;
  localparam int BEATS   = LINE_W / BURST_W;

  logic               clk;
  logic               rst_n;
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [ADDR_W-1:0]  address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W-1:0]  q_addr[$];
  logic [LINE_W-1:0]  q_line[$];
  logic [BURST_W-1:0] q_beat[$];

  cacheline_adaptor #(
    .LINE_W (LINE_W),
    .BURST_W(BURST_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_i   (line_i),
    .line_o   (line_o),
    .address_i(address_i),
    .read_i   (read_i),
    .write_i  (write_i),
    .resp_o   (resp_o),
    .burst_i  (burst_i),
    .burst_o  (burst_o),
    .address_o(address_o),
    .read_o   (read_o),
    .write_o  (write_o),
    .resp_i   (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 = read, 1 = write, 2 = read and write requested together.
  // pat holds the resp_i sequence, bit 0 first, plen entries long.
  task automatic do_xfer(input int mode, input logic [ADDR_W-1:0] addr,
                         input logic [LINE_W-1:0] wline,
                         input logic [LINE_W-1:0] wline_alt,
                         input logic [LINE_W-1:0] rline,
                         input logic [31:0] pat, input int plen,
                         input string tag);
    bit is_wr;
    int hi_cnt;
    int other_hi;
    int beat_idx;
    int cyc;
    logic p;
    is_wr = (mode == 1);
    q_addr.push_back({addr[ADDR_W-1:5], 5'b0});
    if (is_wr) begin
      for (int b = 0; b < BEATS; b++) q_beat.push_back(wline[b*BURST_W +: BURST_W]);
    end else begin
      q_line.push_back(rline);
    end
    read_i    = (mode != 1);
    write_i   = (mode != 0);
    address_i = addr;
    line_i    = wline;
    tick();
    read_i  = 1'b0;
    write_i = 1'b0;
    line_i  = wline_alt;
    check({tag, "_addr"}, LINE_W'(address_o), LINE_W'(q_addr.pop_front()));
    hi_cnt = 0; other_hi = 0; beat_idx = 0; cyc = 0;
    while (!resp_o && cyc < 40) begin
      if (is_wr ? write_o : read_o) hi_cnt++;
      if (is_wr ? read_o : write_o) other_hi++;
      p = (cyc < plen) ? pat[cyc] : 1'b0;
      resp_i = p;
      if (is_wr && p) begin
        check({tag, "_burst"}, LINE_W'(burst_o), LINE_W'(q_beat.pop_front()));
      end
      if (!is_wr && p) begin
        burst_i = rline[beat_idx*BURST_W +: BURST_W];
      end else begin
        burst_i = {$urandom, $urandom};
      end
      if (p) beat_idx++;
      tick();
      cyc++;
    end
    resp_i = 1'b0;
    check({tag, "_resp"}, LINE_W'(resp_o), LINE_W'(1'b1));
    check({tag, "_latency"}, LINE_W'(cyc), LINE_W'(plen));
    check({tag, "_req_cycles"}, LINE_W'(hi_cnt), LINE_W'(plen));
    check({tag, "_other_req"}, LINE_W'(other_hi), LINE_W'(0));
    if (!is_wr) begin
      check({tag, "_line"}, line_o, q_line.pop_front());
    end
    tick();
    check({tag, "_resp_pulse"}, LINE_W'(resp_o), LINE_W'(1'b0));
    check({tag, "_req_drop"}, LINE_W'({read_o, write_o}), LINE_W'(2'b00));
  endtask

  logic [LINE_W-1:0] line_a;
  logic [LINE_W-1:0] line_b;
  logic [LINE_W-1:0] line_w;
  logic [LINE_W-1:0] line_w_alt;
  int bad;

  initial begin
    rst_n = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0;
    line_a = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
    line_b = {{4{16'h0F0F}}, {4{16'h5A5A}}, {4{16'hC3C3}}, {4{16'h9696}}};
    line_w = {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}};
    line_w_alt = ~line_w;

    // Reset and idle with memory handshake toggling
    tick();
    tick();
    check("rst_outputs", LINE_W'({read_o, write_o, resp_o}), LINE_W'(3'b000));
    check("rst_line", line_o, '0);
    check("rst_addr", LINE_W'(address_o), '0);
    check("rst_burst", LINE_W'(burst_o), '0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      resp_i  = i[0];
      burst_i = {$urandom, $urandom};
      tick();
      if (read_o || write_o || resp_o || line_o != '0) bad++;
    end
    resp_i = 1'b0;
    check("idle_quiet", LINE_W'(bad), '0);

    // Contiguous read
    do_xfer(0, 32'h0000_1234, '0, '0, line_a, 32'b1111, 4, "rd_contig");

    // Stalled read: resp_i 1,0,0,1,1,0,1
    do_xfer(0, 32'h0000_1234, '0, '0, line_a, 32'b1011001, 7, "rd_stall");

    // Write with line_i changed after the request
    do_xfer(1, 32'h8000_0040, line_w, line_w_alt, '0, 32'b1111, 4, "wr");
    check("wr_keeps_line_o", line_o, line_a);

    // Stalled write
    do_xfer(1, 32'h8000_007F, line_b, line_w, '0, 32'b110101, 6, "wr_stall");

    // Simultaneous requests: read wins
    do_xfer(2, 32'h0000_ABCD, line_w, line_w, line_b, 32'b1111, 4, "rd_wr");

    // Reset after two read beats
    read_i = 1'b1;
    address_i = 32'h0000_0100;
    tick();
    read_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      resp_i  = 1'b1;
      burst_i = line_a[i*BURST_W +: BURST_W];
      tick();
    end
    resp_i = 1'b0;
    rst_n  = 1'b0;
    tick();
    check("midrst_outputs", LINE_W'({read_o, write_o, resp_o}), LINE_W'(3'b000));
    check("midrst_line", line_o, '0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1;
      tick();
      if (read_o || resp_o) bad++;
    end
    resp_i = 1'b0;
    check("midrst_no_resp", LINE_W'(bad), '0);
    do_xfer(0, 32'h0000_0120, '0, '0, line_b, 32'b1111, 4, "rd_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits between the cache controller's physical-memory port (pmem_read/pmem_write/pmem_resp, one 256-bit line) and main memory, which moves data in 64-bit bursts.
- Converts one line request into BEATS consecutive burst transfers.
  - Reads: assembles the incoming beats into a line.
  - Writes: serialises a latched line into beats.
- Returns a single-cycle completion pulse to the cache.

Parameters:
- LINE_W, 256, cacheline width in bits.
- BURST_W, 64, memory beat width in bits. LINE_W must be an integer multiple of BURST_W.
- ADDR_W, 32, address width.
- BEATS, LINE_W/BURST_W (4), derived. Not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- line_i  in  LINE_W  write line from cache datapath.
- line_o  out  LINE_W  assembled read line to cache datapath.
- address_i  in  ADDR_W  line address from cache.
- read_i  in  1  line read request (cache pmem_read).
- write_i  in  1  line write request (cache pmem_write).
- resp_o  out  1  line transfer complete (cache pmem_resp).
- burst_i  in  BURST_W  read beat from memory.
- burst_o  out  BURST_W  write beat to memory.
- address_o  out  ADDR_W  line-aligned address to memory.
- read_o  out  1  burst read request.
- write_o  out  1  burst write request.
- resp_i  in  1  memory beat handshake; one beat moves per cycle in which it is high.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
  - rst_n low at an edge: state=IDLE, beat counter=0, line_o=0, burst_o=0, address_o=0, read_o=0, write_o=0, resp_o=0.
  - Reset mid-transfer abandons the transfer; no resp_o is produced.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - read_i=1 at an edge: latch address_o = {address_i[ADDR_W-1:5], 5'b0}, clear counter, go READ.
  - Else write_i=1 at an edge: latch the same address, latch line_i into an internal shift buffer, clear counter, go WRITE.
  - Both high: read wins.
  - resp_i and burst_i are ignored.
- READ:
  - read_o=1 and address_o held for the whole state.
  - On each edge with resp_i=1: line_o[cnt*BURST_W +: BURST_W] <= burst_i, cnt++.
  - When resp_i=1 with cnt==BEATS-1: go DONE. read_o drops in the next cycle.
  - resp_i=0 cycles stall with no change; gaps between beats are legal.
- WRITE:
  - write_o=1, address_o held, burst_o = buffered beat[cnt], beat 0 = bits [63:0].
  - On each edge with resp_i=1: cnt++ and burst_o advances to the next beat.
  - When resp_i=1 with cnt==BEATS-1: go DONE.
  - The buffered line is unaffected by line_i changes after latching.
- DONE:
  - resp_o=1 for exactly one cycle; read_o=write_o=0.
  - Unconditionally returns to IDLE.
  - Requests are not sampled in DONE. The cache drops read_i/write_i on the cycle after it sees resp_o, so there is no spurious restart.
- line_o holds the last completed read line until the next read's beats overwrite it. It is not cleared by writes.
- resp_i arriving in IDLE or DONE: ignored, no state change.
- Latency: request edge T0, contiguous resp_i in cycles 1..BEATS, resp_o high in cycle BEATS+1. The cache sees a 6-cycle minimum miss fill.
- Counter width: clog2(BEATS). It wraps to 0 on the final beat.

Test Plan:
- Reset and idle:
  - Stimulus: rst_n=0 for 2 cycles, then idle with resp_i toggling.
  - Required: all outputs 0, no read_o/write_o, no resp_o.
- Contiguous read:
  - Stimulus: read_i=1, address_i=0x0000_1234; memory returns resp_i for 4 cycles with burst_i=0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Required: address_o=0x0000_1220; read_o high exactly 4 cycles; resp_o one cycle later; line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Stalled read:
  - Stimulus: same read with resp_i pattern 1,0,0,1,1,0,1.
  - Required: same line_o; resp_o on the cycle after the 4th accepted beat; read_o held through the gaps.
- Write:
  - Stimulus: write_i=1, address_i=0x8000_0040, line_i=256'h DDDD…_CCCC…_BBBB…_AAAA…; change line_i right after the start; resp_i for 4 cycles.
  - Required: burst_o = AAAA…, BBBB…, CCCC…, DDDD… on successive accepted beats, unaffected by the line_i change; write_o high 4 cycles; resp_o single pulse.
- Simultaneous read and write request:
  - Stimulus: read_i=1 and write_i=1 together.
  - Required: read transaction runs; write_o stays 0.
- Reset mid-transfer:
  - Stimulus: assert rst_n=0 after 2 read beats, then issue a fresh read.
  - Required: immediate IDLE, no resp_o; the fresh read completes normally with its own data.
